// File: rtl/viterbi_pkg.sv
// Shared types and default constants for the Viterbi decoder sequencing controller.
package viterbi_pkg;

  localparam int TB_LEN_DEF  = 16;
  localparam int ACS_LAT_DEF = 2;

  typedef logic [1:0] sym_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACS  = 3'd1,
    WR   = 3'd2,
    TB   = 3'd3,
    OUT  = 3'd4
  } vctrl_state_e;

endpackage

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder sequencer: symbol intake, ACS stepping, circular survivor writes and
// sliding-window traceback producing one decoded bit per symbol once the window is full.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int TB_LEN  = TB_LEN_DEF,
  parameter int ACS_LAT = ACS_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sym_valid,
  output logic                      sym_ready,
  input  logic [1:0]                sym_cx,
  input  logic                      sym_sof,
  output logic                      bmu_cx0,
  output logic                      bmu_cx1,
  output logic                      acs_en,
  output logic                      pm_clr,
  output logic                      sm_wr_en,
  output logic [$clog2(TB_LEN)-1:0] sm_wr_addr,
  output logic                      tb_en,
  output logic                      tb_first,
  output logic [$clog2(TB_LEN)-1:0] sm_rd_addr,
  input  logic                      tb_bit,
  output logic                      dec_valid,
  output logic                      dec_bit,
  input  logic                      dec_ready,
  output logic                      busy
);

  localparam int AW = $clog2(TB_LEN);
  localparam int FW = AW + 1;
  localparam int CW = (ACS_LAT > 1) ? $clog2(ACS_LAT) : 1;
  localparam logic [CW-1:0] ACS_LAST = CW'(ACS_LAT - 1);
  localparam logic [AW-1:0] TB_LAST  = AW'(TB_LEN - 1);
  localparam logic [FW-1:0] FULL     = FW'(TB_LEN);

  vctrl_state_e  state_r, state_s;
  logic [CW-1:0] acs_cnt_r, acs_cnt_s;
  logic [AW-1:0] tb_cnt_r, tb_cnt_s;
  logic [AW-1:0] wr_ptr_r, wr_ptr_s;
  logic [FW-1:0] fill_r, fill_s, fill_upd_s;
  logic          sof_r, sof_s;
  sym_t          bmu_s;
  logic          acs_en_s, pm_clr_s, sm_wr_en_s, tb_en_s, tb_first_s;
  logic          dec_valid_s, dec_bit_s;
  logic [AW-1:0] sm_wr_addr_s, sm_rd_addr_s;

  assign sym_ready = (state_r == IDLE);
  assign busy      = ~sym_ready;

  // Window occupancy after the current write: a frame start restarts it, otherwise saturate.
  always_comb begin
    fill_upd_s = fill_r;
    if (sof_r) begin
      fill_upd_s = FW'(1);
    end else if (fill_r == FULL) begin
      fill_upd_s = FULL;
    end else begin
      fill_upd_s = fill_r + FW'(1);
    end
  end

  // Next state, counters and next value of every registered output.
  always_comb begin
    state_s      = state_r;
    acs_cnt_s    = acs_cnt_r;
    tb_cnt_s     = tb_cnt_r;
    wr_ptr_s     = wr_ptr_r;
    fill_s       = fill_r;
    sof_s        = sof_r;
    bmu_s        = {bmu_cx1, bmu_cx0};
    dec_valid_s  = dec_valid;
    dec_bit_s    = dec_bit;
    acs_en_s     = 1'b0;
    pm_clr_s     = 1'b0;
    sm_wr_en_s   = 1'b0;
    sm_wr_addr_s = '0;
    tb_en_s      = 1'b0;
    tb_first_s   = 1'b0;
    sm_rd_addr_s = '0;
    case (state_r)
      IDLE: begin
        if (sym_valid) begin
          bmu_s     = sym_cx;
          sof_s     = sym_sof;
          acs_cnt_s = '0;
          acs_en_s  = 1'b1;
          pm_clr_s  = sym_sof;
          state_s   = ACS;
        end else begin
          state_s = IDLE;
        end
      end
      ACS: begin
        if (acs_cnt_r == ACS_LAST) begin
          sm_wr_en_s   = 1'b1;
          sm_wr_addr_s = wr_ptr_r;
          state_s      = WR;
        end else begin
          acs_cnt_s = acs_cnt_r + CW'(1);
          acs_en_s  = 1'b1;
        end
      end
      WR: begin
        wr_ptr_s = wr_ptr_r + AW'(1);
        fill_s   = fill_upd_s;
        if (fill_upd_s == FULL) begin
          // Traceback starts from the column just written and walks backwards.
          tb_cnt_s     = '0;
          tb_en_s      = 1'b1;
          tb_first_s   = 1'b1;
          sm_rd_addr_s = wr_ptr_r;
          state_s      = TB;
        end else begin
          state_s = IDLE;
        end
      end
      TB: begin
        if (tb_cnt_r == TB_LAST) begin
          dec_bit_s   = tb_bit;
          dec_valid_s = 1'b1;
          state_s     = OUT;
        end else begin
          tb_cnt_s     = tb_cnt_r + AW'(1);
          tb_en_s      = 1'b1;
          sm_rd_addr_s = sm_rd_addr - AW'(1);
        end
      end
      OUT: begin
        if (dec_ready) begin
          dec_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        dec_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      acs_cnt_r  <= '0;
      tb_cnt_r   <= '0;
      wr_ptr_r   <= '0;
      fill_r     <= '0;
      sof_r      <= 1'b0;
      bmu_cx0    <= 1'b0;
      bmu_cx1    <= 1'b0;
      acs_en     <= 1'b0;
      pm_clr     <= 1'b0;
      sm_wr_en   <= 1'b0;
      sm_wr_addr <= '0;
      tb_en      <= 1'b0;
      tb_first   <= 1'b0;
      sm_rd_addr <= '0;
      dec_valid  <= 1'b0;
      dec_bit    <= 1'b0;
    end else begin
      state_r    <= state_s;
      acs_cnt_r  <= acs_cnt_s;
      tb_cnt_r   <= tb_cnt_s;
      wr_ptr_r   <= wr_ptr_s;
      fill_r     <= fill_s;
      sof_r      <= sof_s;
      bmu_cx0    <= bmu_s[0];
      bmu_cx1    <= bmu_s[1];
      acs_en     <= acs_en_s;
      pm_clr     <= pm_clr_s;
      sm_wr_en   <= sm_wr_en_s;
      sm_wr_addr <= sm_wr_addr_s;
      tb_en      <= tb_en_s;
      tb_first   <= tb_first_s;
      sm_rd_addr <= sm_rd_addr_s;
      dec_valid  <= dec_valid_s;
      dec_bit    <= dec_bit_s;
    end
  end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl (TB_LEN=4, ACS_LAT=1): directed and random symbols
// checked against a per-symbol timeline model of window fill, columns and traceback order.
module tb_viterbi_ctrl;

  localparam int TBL = 4;
  localparam int AL  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [1:0] sym_cx = 2'b00;
  logic       sym_sof = 1'b0;
  logic       bmu_cx0, bmu_cx1, acs_en, pm_clr, sm_wr_en, tb_en, tb_first;
  logic [1:0] sm_wr_addr, sm_rd_addr;
  logic       tb_bit = 1'b0;
  logic       dec_valid, dec_bit;
  logic       dec_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int m_wr   = 0;
  int m_fill = 0;
  bit aborted = 1'b0;

  viterbi_ctrl #(.TB_LEN(TBL), .ACS_LAT(AL)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_cx(sym_cx), .sym_sof(sym_sof), .bmu_cx0(bmu_cx0), .bmu_cx1(bmu_cx1),
    .acs_en(acs_en), .pm_clr(pm_clr), .sm_wr_en(sm_wr_en), .sm_wr_addr(sm_wr_addr),
    .tb_en(tb_en), .tb_first(tb_first), .sm_rd_addr(sm_rd_addr), .tb_bit(tb_bit),
    .dec_valid(dec_valid), .dec_bit(dec_bit), .dec_ready(dec_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_outs"}, {19'd0, bmu_cx0, bmu_cx1, acs_en, pm_clr, sm_wr_en, tb_en, tb_first,
                         dec_valid, dec_bit, sm_wr_addr, sm_rd_addr}, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    sym_valid = 1'b0; dec_ready = 1'b0; tb_bit = 1'b0;
    #1 chk_rst_vals("reset");
    m_wr = 0; m_fill = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", sym_ready, 32'd1);
  endtask

  // One symbol end to end; abort_k >= 0 pulls reset at that traceback step.
  task automatic send(input logic [1:0] cx, input bit sof, input int hold,
                      input int last_bit, input int abort_k);
    int col;
    int exp_bit;
    int b;
    bit stop;
    exp_bit = 0;
    stop = 1'b0;
    chk("ready_before", sym_ready, 32'd1);
    sym_valid = 1'b1; sym_cx = cx; sym_sof = sof;
    @(negedge clk);
    sym_valid = 1'b0; sym_sof = 1'b0;
    for (int a = 0; a < AL; a++) begin
      chk("acs_en", acs_en, 32'd1);
      chk("pm_clr", pm_clr, {31'd0, (a == 0) && sof});
      chk("bmu_cx", {bmu_cx1, bmu_cx0}, cx);
      chk("ready_acs", sym_ready, 32'd0);
      chk("tb_en_acs", tb_en, 32'd0);
      @(negedge clk);
    end
    chk("wr_en", sm_wr_en, 32'd1);
    chk("wr_addr", sm_wr_addr, m_wr);
    chk("acs_en_wr", acs_en, 32'd0);
    col    = m_wr;
    m_wr   = (m_wr + 1) % TBL;
    m_fill = sof ? 1 : ((m_fill < TBL) ? m_fill + 1 : TBL);
    @(negedge clk);
    if (m_fill != TBL) begin
      chk("ready_fill", sym_ready, 32'd1);
      chk("tb_en_fill", tb_en, 32'd0);
      chk("dec_valid_fill", dec_valid, 32'd0);
    end else begin
      for (int k = 0; k < TBL; k++) begin
        if (!stop) begin
          if (k == abort_k) begin
            #1 rst_n = 1'b0;
            tb_bit = 1'b0;
            #1 chk_rst_vals("abort");
            m_wr = 0; m_fill = 0;
            aborted = 1'b1;
            stop = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            chk("abort_ready", sym_ready, 32'd1);
          end else begin
            chk("tb_en", tb_en, 32'd1);
            chk("tb_first", tb_first, {31'd0, k == 0});
            chk("rd_addr", sm_rd_addr, (col - k + TBL) % TBL);
            chk("acs_tb_excl", {acs_en, sm_wr_en, dec_valid}, 32'd0);
            b = (k == TBL - 1 && last_bit >= 0) ? last_bit : int'($urandom_range(0, 1));
            tb_bit  = b[0];
            exp_bit = b;
            @(negedge clk);
          end
        end
      end
      if (!stop) begin
        tb_bit = 1'b0;
        for (int h = 0; h < hold; h++) begin
          chk("dec_valid_hold", dec_valid, 32'd1);
          chk("dec_bit_hold", dec_bit, exp_bit);
          chk("ready_hold", sym_ready, 32'd0);
          chk("tb_en_hold", tb_en, 32'd0);
          @(negedge clk);
        end
        chk("dec_valid", dec_valid, 32'd1);
        chk("dec_bit", dec_bit, exp_bit);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        chk("dec_valid_clr", dec_valid, 32'd0);
        chk("ready_after", sym_ready, 32'd1);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_rst_vals("init");
    chk("init_ready", sym_ready, 32'd1);
    rst_n = 1'b1;
    chk("init_ready_rel", sym_ready, 32'd1);

    send(2'b10, 1'b0, 0, -1, -1);
    do_reset();

    send(2'b01, 1'b1, 0, -1, -1);
    send(2'b11, 1'b0, 0, -1, -1);
    send(2'b00, 1'b0, 0, -1, -1);
    send(2'b10, 1'b0, 0, 1, -1);
    send(2'b11, 1'b0, 10, -1, -1);

    send(2'b01, 1'b1, 0, -1, -1);
    send(2'b10, 1'b0, 0, -1, -1);
    send(2'b00, 1'b0, 0, -1, -1);
    send(2'b11, 1'b0, 1, 0, -1);

    for (int i = 0; i < 16; i++) begin
      send(2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 3)), -1, -1);
    end

    aborted = 1'b0;
    for (int i = 0; i < TBL + 1; i++) begin
      if (!aborted) send(2'($urandom_range(0, 3)), 1'b0, 0, -1, 1);
    end
    chk("abort_reached", {31'd0, aborted}, 32'd1);
    send(2'b10, 1'b0, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
Sequencing controller for the Viterbi decoder datapath: BMU, ACS array, survivor memory and traceback unit. It accepts received symbol pairs over a valid/ready handshake and drives the registered BMU inputs. It then steps the ACS array, writes one survivor column per symbol into a circular survivor memory, and runs a sliding-window traceback. Output is one decoded bit per symbol once the window is full.

Parameters:
TB_LEN, 16, traceback depth; survivor memory depth in columns; power of two, minimum 4
ACS_LAT, 2, cycles acs_en is held per symbol; minimum 1
AW, $clog2(TB_LEN), survivor memory address width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sym_valid  in  1  input symbol valid
sym_ready  out  1  controller can accept a symbol
sym_cx  in  2  received symbol; bit0 = cx0, bit1 = cx1
sym_sof  in  1  start of frame, qualified by the handshake
bmu_cx0  out  1  registered cx0 to BMU
bmu_cx1  out  1  registered cx1 to BMU
acs_en  out  1  ACS array update enable
pm_clr  out  1  path metrics reset to start state for this symbol
sm_wr_en  out  1  survivor column write strobe
sm_wr_addr  out  AW  survivor write column
tb_en  out  1  traceback step enable
tb_first  out  1  first traceback step; traceback unit loads best state
sm_rd_addr  out  AW  survivor read column
tb_bit  in  1  decoded bit from traceback unit, valid while tb_en
dec_valid  out  1  decoded bit valid
dec_bit  out  1  decoded bit
dec_ready  in  1  downstream accepts decoded bit
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_ptr=0; fill=0.
  - bmu_cx0, bmu_cx1, acs_en, pm_clr, sm_wr_en, tb_en, tb_first, dec_valid, dec_bit = 0.
  - sm_wr_addr=0, sm_rd_addr=0.
- sym_ready = (state==IDLE), combinational; it reads 1 immediately after reset release. busy = !sym_ready.
- FSM states: IDLE, ACS, WR, TB, OUT.
- IDLE:
  - On sym_valid&&sym_ready at cycle T: {bmu_cx1,bmu_cx0} <= sym_cx; sof_q <= sym_sof; go to ACS.
  - No handshake: hold state and all registered outputs.
- ACS:
  - acs_en=1 for exactly ACS_LAT cycles, T+1 .. T+ACS_LAT.
  - pm_clr=1 only on cycle T+1, and only if sof_q.
  - Then go to WR.
- WR, one cycle:
  - sm_wr_en=1 with sm_wr_addr=wr_ptr; then wr_ptr <= wr_ptr+1, modulo TB_LEN (natural AW-bit wrap).
  - fill: if sof_q, fill <= 1; else fill <= min(fill+1, TB_LEN), saturating.
  - If the new fill == TB_LEN, go to TB; else go to IDLE.
- TB, exactly TB_LEN cycles, k = 0..TB_LEN-1:
  - tb_en=1; tb_first=1 only at k=0; sm_rd_addr = last written column - k, mod TB_LEN (newest first, oldest last).
  - At k=TB_LEN-1, dec_bit <= tb_bit; then go to OUT.
- OUT:
  - dec_valid=1; dec_bit held stable until dec_valid&&dec_ready.
  - On acceptance: dec_valid <= 0 and go to IDLE; backpressure may last indefinitely.
- Throughput:
  - Full window: one symbol per ACS_LAT+TB_LEN+3 cycles when dec_ready=1.
  - Filling window: one symbol per ACS_LAT+2 cycles.
- sof mid-stream: the first TB_LEN-1 symbols of the new frame produce no output. Bits still pending from the previous frame are dropped; no flush in this block.
- Survivor columns are written in the WR cycle and read no earlier than the next cycle. No read/write collision on the same column is possible.
- acs_en and tb_en are never asserted together.
- Outputs not listed for a state are 0 in that state.
- Reset asserted mid-operation: immediate return to reset values. A pending dec_valid is discarded.

Decomposition:
- Package viterbi_pkg:
  - state enum typedef vctrl_state_e {IDLE, ACS, WR, TB, OUT}.
  - default constants TB_LEN_DEF=16, ACS_LAT_DEF=2.
  - typedef sym_t = logic [1:0].
- Single module with no sub-module; the FSM with its counters (acs_cnt, tb_cnt, fill, wr_ptr) fits naturally in one block.

Test Plan:
- Reset then idle, TB_LEN=4, ACS_LAT=1 -> sym_ready=1, all other outputs 0, sm_wr_addr=0.
- Accept sym_cx=2'b10 at T -> bmu_cx1=1, bmu_cx0=0 at T+1; acs_en=1 at T+1 only; sm_wr_en=1 addr=0 at T+2; back in IDLE with sym_ready=1 at T+3; no tb_en.
- Four symbols with sof on the first -> pm_clr only at the first symbol's T+1; writes to columns 0,1,2,3. After the 4th WR: tb_en for 4 cycles with sm_rd_addr 3,2,1,0, tb_first on the first cycle only; tb_bit driven 1 on the last TB cycle -> dec_valid=1, dec_bit=1.
- Fifth symbol -> write to column 0 (wrap); traceback reads 0,3,2,1; one decoded bit emitted.
- Hold dec_ready=0 for 10 cycles -> dec_valid and dec_bit stable, sym_ready=0 throughout; dec_ready=1 -> IDLE next cycle.
- sym_sof mid-stream after a full window -> fill restarts at 1; next 3 symbols give no tb_en; 4th symbol of the frame triggers traceback.
- rst_n low during TB -> outputs go to reset values asynchronously; after release, first symbol writes column 0.
